// File: rtl/freq_step_ctrl_if.sv
// Bus bundle between the key front end and the DDS core.
// Signal encoding of dbg_state: 0 IDLE, 1 WAIT, 2 RPT, 3 LOCK.
// Handshake: there is no valid/ready pair here. K is always valid and may be
// sampled on any cycle. k_upd is a one-cycle qualifier that is high only on
// the cycle K first shows a new value.
interface freq_step_ctrl_if #(
  parameter int KW = 24
);
  logic          key_inc;
  logic          key_dec;
  logic [1:0]    step_sel;
  logic [KW-1:0] K;
  logic          k_upd;
  logic          at_min;
  logic          at_max;
  logic [1:0]    dbg_state;

  modport master (
    output key_inc, key_dec, step_sel,
    input  K, k_upd, at_min, at_max, dbg_state
  );

  modport slave (
    input  key_inc, key_dec, step_sel,
    output K, k_upd, at_min, at_max, dbg_state
  );
endinterface

// File: rtl/freq_step_ctrl.sv
// Push-button front end for the DDS: synchronises and debounces the inc/dec
// keys, detects presses, auto-repeats on hold and keeps a saturated tuning word.
module freq_step_ctrl #(
  parameter int            KW        = 24,
  parameter logic [KW-1:0] K_RESET   = 24'd168,
  parameter logic [KW-1:0] K_MIN     = 24'd1,
  parameter logic [KW-1:0] K_MAX     = 24'h800000,
  parameter int            DB_CNT    = 1_000_000,
  parameter int            RPT_DELAY = 50_000_000,
  parameter int            RPT_RATE  = 10_000_000
) (
  input logic       clk,
  input logic       rst_n,
  freq_step_ctrl_if.slave bus
);

  localparam int DBW     = $clog2(DB_CNT + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RPT  = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  // Index 0 is the increment key, index 1 the decrement key (both active-low).
  logic [1:0]     w_key_raw;
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_db;
  logic [1:0]     r_db_d;
  logic [1:0]     r_arm;
  logic [DBW-1:0] r_db_cnt [2];
  logic [1:0]     w_press;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_dir;
  logic           w_dir_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_step;
  logic           w_act_rel;
  logic           w_oth_press;

  logic [KW:0]    w_step_amt;
  logic [KW:0]    w_sum;
  logic [KW:0]    w_diff;
  logic [KW-1:0]  w_k_nxt;
  logic [KW-1:0]  r_k;
  logic           r_k_upd;
  logic           r_at_min;
  logic           r_at_max;

  assign w_key_raw = {bus.key_dec, bus.key_inc};

  // Synchroniser, debounce counters and arming. A key is only armed once its
  // synchronised level has been seen released after reset, so a key held
  // through reset cannot count towards a press until it is let go.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_db    <= 2'b11;
      r_db_d  <= 2'b11;
      r_arm   <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_arm   <= r_arm | r_sync2;
      for (int i = 0; i < 2; i++) begin
        if (!r_arm[i] || (r_sync2[i] == r_db[i])) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DB_CNT - 1)) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_press     = r_db_d & ~r_db;
  assign w_act_rel   = r_dir ? r_db[0] : r_db[1];
  assign w_oth_press = r_dir ? w_press[1] : w_press[0];

  // FSM state register together with its direction and delay/rate counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: decides when a step is applied and where the FSM goes.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (&w_press) begin
          w_state_nxt = S_LOCK;
        end else if (w_press[0] || w_press[1]) begin
          w_state_nxt = S_WAIT;
          w_dir_nxt   = w_press[0];
          w_cnt_nxt   = '0;
          w_step      = 1'b1;
        end
      end
      S_WAIT, S_RPT: begin
        if (w_oth_press) begin
          w_state_nxt = S_LOCK;
        end else if (w_act_rel) begin
          w_state_nxt = S_IDLE;
        end else if (((r_state == S_WAIT) && (r_cnt == CW'(RPT_DELAY - 1))) ||
                     ((r_state == S_RPT)  && (r_cnt == CW'(RPT_RATE - 1)))) begin
          w_state_nxt = S_RPT;
          w_cnt_nxt   = '0;
          w_step      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LOCK: begin
        if (&r_db) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_step_amt = (KW + 1)'(1) << {bus.step_sel, 2'b00};
  assign w_sum      = {1'b0, r_k} + w_step_amt;
  assign w_diff     = {1'b0, r_k} - w_step_amt;

  // Output logic: saturated next tuning word, computed one bit wider than K.
  always_comb begin
    w_k_nxt = r_k;
    if (w_step) begin
      if (w_dir_nxt) begin
        w_k_nxt = (w_sum > {1'b0, K_MAX}) ? K_MAX : w_sum[KW-1:0];
      end else begin
        w_k_nxt = (w_diff[KW] || (w_diff < {1'b0, K_MIN})) ? K_MIN : w_diff[KW-1:0];
      end
    end
  end

  // Tuning word and its flags, all registered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k      <= K_RESET;
      r_k_upd  <= 1'b0;
      r_at_min <= (K_RESET == K_MIN);
      r_at_max <= (K_RESET == K_MAX);
    end else begin
      r_k      <= w_k_nxt;
      r_k_upd  <= (w_k_nxt != r_k);
      r_at_min <= (w_k_nxt == K_MIN);
      r_at_max <= (w_k_nxt == K_MAX);
    end
  end

  assign bus.K         = r_k;
  assign bus.k_upd     = r_k_upd;
  assign bus.at_min    = r_at_min;
  assign bus.at_max    = r_at_max;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Bench for freq_step_ctrl with reduced timing parameters.
module tb_freq_step_ctrl;

  localparam int K_RST     = 100;
  localparam int KMIN      = 1;
  localparam int KMAX      = 5000;
  localparam int DB_CNT    = 4;
  localparam int RPT_DELAY = 20;
  localparam int RPT_RATE  = 5;

  logic clk;
  logic rst_n;

  freq_step_ctrl_if #(.KW(24)) bus ();

  freq_step_ctrl #(
    .KW(24), .K_RESET(24'd100), .K_MIN(24'd1), .K_MAX(24'd5000),
    .DB_CNT(DB_CNT), .RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          n_checks;
  int          n_pass;
  int          model_k;
  int          exp_t_q[$];
  logic [23:0] exp_q[$];

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end

  // Reference: one saturated step from the rules, in plain integers.
  function automatic int model_step(input int k, input bit inc, input int sel);
    int step;
    step = 1 << (4 * sel);
    if (inc) return (k + step > KMAX) ? KMAX : k + step;
    else     return (k - step < KMIN) ? KMIN : k - step;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_k = K_RST;
  endtask

  // Hold one key low for h cycles, then release; the expected step edges are
  // derived from the timing rules (first step at DB_CNT+3, then after
  // RPT_DELAY, then every RPT_RATE, until the debounced release).
  task automatic do_hold(input string name, input bit inc, input int h, input int sel);
    int t;
    int k;
    int nk;
    int et;
    logic [23:0] ek;
    exp_t_q.delete();
    exp_q.delete();
    bus.step_sel = sel[1:0];
    k = model_k;
    if (h >= DB_CNT) begin
      t = DB_CNT + 3;
      while (t <= h + DB_CNT + 2) begin
        nk = model_step(k, inc, sel);
        if (nk != k) begin
          exp_t_q.push_back(t);
          exp_q.push_back(24'(nk));
        end
        k = nk;
        t = (t == DB_CNT + 3) ? t + RPT_DELAY : t + RPT_RATE;
      end
    end
    @(posedge clk);
    #1;
    if (inc) bus.key_inc = 1'b0; else bus.key_dec = 1'b0;
    for (int cyc = 1; cyc <= h + 20; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.k_upd === 1'b1) begin
        n_checks++;
        if (exp_t_q.size() == 0) begin
          $display("FAIL %s unexpected_k_upd: cyc=%0d K=%0d, required no pulse", name, cyc, bus.K);
        end else begin
          et = exp_t_q.pop_front();
          ek = exp_q.pop_front();
          if (cyc !== et || bus.K !== ek)
            $display("FAIL %s step: cyc=%0d K=%0d, required cyc=%0d K=%0d", name, cyc, bus.K, et, ek);
          else n_pass++;
          n_checks++;
          if (bus.at_min !== (ek == 24'(KMIN)) || bus.at_max !== (ek == 24'(KMAX)))
            $display("FAIL %s flags: at_min=%b at_max=%b, required %b %b", name, bus.at_min,
                     bus.at_max, (ek == 24'(KMIN)), (ek == 24'(KMAX)));
          else n_pass++;
        end
      end
      if (cyc == h) begin
        if (inc) bus.key_inc = 1'b1; else bus.key_dec = 1'b1;
      end
    end
    n_checks++;
    if (exp_t_q.size() != 0)
      $display("FAIL %s missing_steps: %0d pulses missing, required 0", name, exp_t_q.size());
    else n_pass++;
    n_checks++;
    if (bus.K !== 24'(k) || bus.at_min !== (k == KMIN) || bus.at_max !== (k == KMAX))
      $display("FAIL %s final: K=%0d min=%b max=%b, required K=%0d min=%b max=%b", name,
               bus.K, bus.at_min, bus.at_max, k, (k == KMIN), (k == KMAX));
    else n_pass++;
    model_k = k;
  endtask

  task automatic goto_k(input int target);
    int diff;
    int sel;
    int guard;
    guard = 0;
    while (model_k != target && guard < 100) begin
      diff = (target > model_k) ? target - model_k : model_k - target;
      sel = 3;
      while (sel > 0 && (1 << (4 * sel)) > diff) sel--;
      do_hold("goto", target > model_k, 8, sel);
      guard++;
    end
  endtask

  task automatic test_reset();
    bus.key_inc  = 1'b1;
    bus.key_dec  = 1'b1;
    bus.step_sel = 2'b00;
    apply_reset();
    n_checks++;
    if (bus.K !== 24'd100 || bus.k_upd !== 1'b0 || bus.at_min !== 1'b0 ||
        bus.at_max !== 1'b0 || bus.dbg_state !== 2'd0)
      $display("FAIL reset_values: K=%0d k_upd=%b min=%b max=%b st=%0d, required 100 0 0 0 0",
               bus.K, bus.k_upd, bus.at_min, bus.at_max, bus.dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_held_key();
    int pulses;
    bus.step_sel = 2'b00;
    @(posedge clk);
    #1;
    bus.key_inc = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (bus.K !== 24'd101) $display("FAIL pre_reset_step: K=%0d, required 101", bus.K);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (bus.K !== 24'd100) $display("FAIL mid_press_reset: K=%0d, required 100", bus.K);
    else n_pass++;
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.k_upd === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || bus.K !== 24'd100)
      $display("FAIL held_through_reset: pulses=%0d K=%0d, required 0 100", pulses, bus.K);
    else n_pass++;
    bus.key_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    do_hold("repress_after_reset", 1'b1, 10, 0);
  endtask

  task automatic test_single_and_glitch();
    apply_reset();
    do_hold("single_press", 1'b1, 10, 1);
    n_checks++;
    if (bus.K !== 24'd116) $display("FAIL single_press_value: K=%0d, required 116", bus.K);
    else n_pass++;
    do_hold("glitch3", 1'b1, 3, 1);
  endtask

  task automatic test_repeat();
    do_hold("repeat_dec", 1'b0, 60, 0);
  endtask

  task automatic test_saturation();
    goto_k(4990);
    do_hold("sat_max", 1'b1, 8, 1);
    do_hold("sat_max_again", 1'b1, 8, 1);
    goto_k(10);
    do_hold("sat_min", 1'b0, 8, 2);
  endtask

  task automatic test_lock();
    int pulses;
    int ek;
    bus.step_sel = 2'b01;
    ek = model_step(model_k, 1'b1, 1);
    pulses = 0;
    @(posedge clk);
    #1;
    bus.key_inc = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.k_upd === 1'b1) begin
        pulses++;
        n_checks++;
        if (cyc !== 7 || bus.K !== 24'(ek))
          $display("FAIL lock_first_step: cyc=%0d K=%0d, required cyc=7 K=%0d", cyc, bus.K, ek);
        else n_pass++;
      end
      if (cyc == 30 || cyc == 60) begin
        n_checks++;
        if (bus.dbg_state !== 2'd3)
          $display("FAIL lock_state cyc=%0d: state=%0d, required 3", cyc, bus.dbg_state);
        else n_pass++;
      end
      if (cyc == 80) begin
        n_checks++;
        if (bus.dbg_state !== 2'd0)
          $display("FAIL lock_exit: state=%0d, required 0", bus.dbg_state);
        else n_pass++;
      end
      if (cyc == 10) bus.key_dec = 1'b0;
      if (cyc == 40) bus.key_dec = 1'b1;
      if (cyc == 60) bus.key_inc = 1'b1;
    end
    n_checks++;
    if (pulses !== 1 || bus.K !== 24'(ek))
      $display("FAIL lock_steps: pulses=%0d K=%0d, required 1 %0d", pulses, bus.K, ek);
    else n_pass++;
    model_k = ek;
    do_hold("after_lock", 1'b1, 8, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_hold("random", 1'($urandom_range(0, 1)), $urandom_range(1, 45), $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.key_inc  = 1'b1;
    bus.key_dec  = 1'b1;
    bus.step_sel = 2'b00;
    test_reset();
    test_reset_held_key();
    test_single_and_glitch();
    test_repeat();
    test_saturation();
    test_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
